fully_connected_fprop_mac_ctrl: RTL and testbench



---
 rtl/fully_connected_fprop_pkg.sv | 37 +++
 rtl/fully_connected_fprop_mul_11ns_6ns_16_1_1.sv | 17 +
 rtl/fully_connected_fprop_mac_ctrl.sv | 176 +++++++++++++++++
 tb/tb_fully_connected_fprop_mac_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fully_connected_fprop_pkg.sv
// Shared widths, FSM state type and output narrowing for the FC forward-prop MAC sequencer.
// Define FC_MAC_CTRL_SAT_EN to saturate output words instead of wrapping them.
package fully_connected_fprop_pkg;

    localparam int X_W       = 11;
    localparam int W_W       = 6;
    localparam int P_W       = 16;
    localparam int ACC_W     = 24;
    localparam int Y_W       = 16;
    localparam int N_IN_MAX  = 256;
    localparam int N_OUT_MAX = 64;
    localparam int IA_W      = $clog2(N_IN_MAX);
    localparam int OA_W      = $clog2(N_OUT_MAX);
    localparam int WA_W      = IA_W + OA_W;

`ifdef FC_MAC_CTRL_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        FC_IDLE  = 3'd0,
        FC_RUN   = 3'd1,
        FC_DRAIN = 3'd2,
        FC_WRITE = 3'd3,
        FC_DONE  = 3'd4
    } fc_ctrl_state_t;

    // Any set bit above the output width means the sum no longer fits a word.
    function automatic logic [Y_W-1:0] sat_trunc(input logic [ACC_W-1:0] acc);
        logic ovf;
        ovf = |acc[ACC_W-1:Y_W];
        return (SAT_EN && ovf) ? {Y_W{1'b1}} : acc[Y_W-1:0];
    endfunction

endpackage

// File: rtl/fully_connected_fprop_mul_11ns_6ns_16_1_1.sv
// Combinational 11x6 unsigned multiplier returning the low 16 bits of the product.
module fully_connected_fprop_mul_11ns_6ns_16_1_1
    import fully_connected_fprop_pkg::*;
(
    input  logic [X_W-1:0] din0,
    input  logic [W_W-1:0] din1,
    output logic [P_W-1:0] dout
);

    logic [P_W-1:0] a;
    logic [P_W-1:0] b;

    assign a    = P_W'(din0);
    assign b    = P_W'(din1);
    assign dout = a * b;

endmodule

// File: rtl/fully_connected_fprop_mac_ctrl.sv
// Sequencer for the FC forward-prop layer: streams x/w reads through one multiplier into an
// accumulator and writes one word per neuron. Define FC_MAC_CTRL_SAT_EN for saturating outputs.
module fully_connected_fprop_mac_ctrl
    import fully_connected_fprop_pkg::*;
(
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [IA_W:0]     n_in,
    input  logic [OA_W:0]     n_out,
    output logic [IA_W-1:0]   x_address0,
    output logic              x_ce0,
    input  logic [X_W-1:0]    x_q0,
    output logic [WA_W-1:0]   w_address0,
    output logic              w_ce0,
    input  logic [W_W-1:0]    w_q0,
    output logic [OA_W-1:0]   y_address0,
    output logic              y_ce0,
    output logic              y_we0,
    output logic [Y_W-1:0]    y_d0
);

    localparam logic [IA_W:0]   IN_ONE  = 1;
    localparam logic [OA_W:0]   OUT_ONE = 1;
    localparam logic [WA_W-1:0] WA_ONE  = 1;

    fc_ctrl_state_t   state_q, state_d;
    logic [IA_W:0]    n_in_q, n_in_d;
    logic [OA_W:0]    n_out_q, n_out_d;
    logic [IA_W:0]    i_q, i_d;
    logic [OA_W:0]    o_q, o_d;
    logic [WA_W-1:0]  w_addr_q, w_addr_d;
    logic             drain_q, drain_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             rd_vld_q;
    logic             prod_vld_q;
    logic [P_W-1:0]   prod_q;
    logic [P_W-1:0]   prod_c;
    logic             last_in;
    logic             last_out;

    assign last_in  = (i_q == n_in_q - IN_ONE);
    assign last_out = (o_q == n_out_q - OUT_ONE);

    fully_connected_fprop_mul_11ns_6ns_16_1_1 u_mul (
        .din0 (x_q0),
        .din1 (w_q0),
        .dout (prod_c)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= FC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FC_IDLE: begin
                if (ap_start) begin
                    if (n_out == '0)     state_d = FC_DONE;
                    else if (n_in == '0) state_d = FC_WRITE;
                    else                 state_d = FC_RUN;
                end
            end
            FC_RUN:   if (last_in) state_d = FC_DRAIN;
            FC_DRAIN: if (drain_q) state_d = FC_WRITE;
            FC_WRITE: begin
                if (last_out)            state_d = FC_DONE;
                else if (n_in_q == '0)   state_d = FC_WRITE;
                else                     state_d = FC_RUN;
            end
            FC_DONE:  state_d = FC_IDLE;
            default:  state_d = FC_IDLE;
        endcase
    end

    always_comb begin
        ap_idle    = 1'b0;
        ap_done    = 1'b0;
        ap_ready   = 1'b0;
        x_ce0      = 1'b0;
        w_ce0      = 1'b0;
        y_ce0      = 1'b0;
        y_we0      = 1'b0;
        y_d0       = '0;
        x_address0 = i_q[IA_W-1:0];
        w_address0 = w_addr_q;
        y_address0 = o_q[OA_W-1:0];
        unique case (state_q)
            FC_IDLE:  ap_idle = 1'b1;
            FC_RUN: begin
                x_ce0 = 1'b1;
                w_ce0 = 1'b1;
            end
            FC_WRITE: begin
                y_ce0 = 1'b1;
                y_we0 = 1'b1;
                y_d0  = sat_trunc(acc_q);
            end
            FC_DONE: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
            end
            default: ;
        endcase
    end

    // Weight address keeps running across neurons, so it only clears on a new start.
    always_comb begin
        n_in_d   = n_in_q;
        n_out_d  = n_out_q;
        i_d      = i_q;
        o_d      = o_q;
        w_addr_d = w_addr_q;
        drain_d  = drain_q;
        acc_d    = prod_vld_q ? acc_q + {{(ACC_W-P_W){1'b0}}, prod_q} : acc_q;
        unique case (state_q)
            FC_IDLE: begin
                if (ap_start) begin
                    n_in_d   = n_in;
                    n_out_d  = n_out;
                    i_d      = '0;
                    o_d      = '0;
                    w_addr_d = '0;
                    acc_d    = '0;
                    drain_d  = 1'b0;
                end
            end
            FC_RUN: begin
                i_d      = i_q + IN_ONE;
                w_addr_d = w_addr_q + WA_ONE;
            end
            FC_DRAIN: drain_d = ~drain_q;
            FC_WRITE: begin
                acc_d = '0;
                i_d   = '0;
                o_d   = o_q + OUT_ONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            n_in_q     <= '0;
            n_out_q    <= '0;
            i_q        <= '0;
            o_q        <= '0;
            w_addr_q   <= '0;
            drain_q    <= 1'b0;
            acc_q      <= '0;
            rd_vld_q   <= 1'b0;
            prod_vld_q <= 1'b0;
            prod_q     <= '0;
        end else begin
            n_in_q     <= n_in_d;
            n_out_q    <= n_out_d;
            i_q        <= i_d;
            o_q        <= o_d;
            w_addr_q   <= w_addr_d;
            drain_q    <= drain_d;
            acc_q      <= acc_d;
            rd_vld_q   <= x_ce0;
            prod_vld_q <= rd_vld_q;
            prod_q     <= prod_c;
        end
    end

endmodule

// File: tb/tb_fully_connected_fprop_mac_ctrl.sv
// Randomized self-checking bench for fully_connected_fprop_mac_ctrl against a dot-product model.
// Honours FC_MAC_CTRL_SAT_EN the same way as the design build.
module tb_fully_connected_fprop_mac_ctrl;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [8:0]  n_in;
    logic [6:0]  n_out;
    logic [7:0]  x_address0;
    logic        x_ce0;
    logic [10:0] x_q0;
    logic [13:0] w_address0;
    logic        w_ce0;
    logic [5:0]  w_q0;
    logic [5:0]  y_address0;
    logic        y_ce0;
    logic        y_we0;
    logic [15:0] y_d0;

    logic [10:0] xMem [256];
    logic [5:0]  wMem [16384];

    logic [5:0]  yAddrQ [$];
    logic [15:0] yDataQ [$];
    logic [13:0] wAddrQ [$];
    logic [7:0]  xAddrQ [$];

    int passCount  = 0;
    int checkCount = 0;

    fully_connected_fprop_mac_ctrl dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .ap_ready   (ap_ready),
        .n_in       (n_in),
        .n_out      (n_out),
        .x_address0 (x_address0),
        .x_ce0      (x_ce0),
        .x_q0       (x_q0),
        .w_address0 (w_address0),
        .w_ce0      (w_ce0),
        .w_q0       (w_q0),
        .y_address0 (y_address0),
        .y_ce0      (y_ce0),
        .y_we0      (y_we0),
        .y_d0       (y_d0)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Activation and weight RAMs with one cycle of read latency.
    always @(posedge ap_clk) begin
        if (x_ce0) x_q0 <= xMem[x_address0];
        if (w_ce0) w_q0 <= wMem[w_address0];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    endtask

    // Each product keeps its low 16 bits; the sum is then narrowed to a 16-bit word.
    function automatic int expectY(input int nIn, input int o);
        longint sum;
        sum = 0;
        for (int i = 0; i < nIn; i++)
            sum += (longint'(xMem[i]) * longint'(wMem[o * nIn + i])) % 65536;
`ifdef FC_MAC_CTRL_SAT_EN
        return (sum > 65535) ? 65535 : int'(sum);
`else
        return int'(sum % 65536);
`endif
    endfunction

    function automatic int expectDone(input int nIn, input int nOut);
        if (nOut == 0) return 1;
        if (nIn == 0)  return nOut + 1;
        return nOut * (nIn + 3) + 1;
    endfunction

    task automatic fillRandom();
        for (int i = 0; i < 256; i++)   xMem[i] = 11'($urandom);
        for (int i = 0; i < 16384; i++) wMem[i] = 6'($urandom);
    endtask

    // Called at a negedge. Starts one run and records every read and write until ap_done.
    task automatic applyStimulus(input int nIn, input int nOut, input bit hold, output int doneCyc);
        int  cyc;
        int  waitCnt;
        bit  seen;
        yAddrQ.delete();
        yDataQ.delete();
        wAddrQ.delete();
        xAddrQ.delete();
        waitCnt = 0;
        while (!ap_idle && waitCnt < 20) begin
            @(negedge ap_clk);
            waitCnt++;
        end
        n_in     = nIn[8:0];
        n_out    = nOut[6:0];
        ap_start = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        if (!hold) begin
            ap_start = 1'b0;
            n_in     = 9'($urandom_range(0, 256));
            n_out    = 7'($urandom_range(0, 64));
        end
        cyc     = 1;
        seen    = 1'b0;
        doneCyc = -1;
        while (!seen && cyc < 20000) begin
            if (x_ce0) xAddrQ.push_back(x_address0);
            if (w_ce0) wAddrQ.push_back(w_address0);
            if (y_we0) begin
                yAddrQ.push_back(y_address0);
                yDataQ.push_back(y_d0);
            end
            if (ap_done) begin
                seen    = 1'b1;
                doneCyc = cyc;
                checkOutput("ready_with_done", ap_ready, 1);
            end else begin
                @(negedge ap_clk);
                cyc++;
            end
        end
    endtask

    task automatic verifyRun(input string name, input int nIn, input int nOut, input int doneCyc);
        checkOutput({name, "_done_cycle"}, doneCyc, expectDone(nIn, nOut));
        checkOutput({name, "_num_writes"}, yAddrQ.size(), nOut);
        for (int o = 0; o < yAddrQ.size() && o < nOut; o++) begin
            checkOutput($sformatf("%s_yaddr%0d", name, o), yAddrQ[o], o);
            checkOutput($sformatf("%s_y%0d", name, o), yDataQ[o], expectY(nIn, o));
        end
        checkOutput({name, "_num_reads"}, wAddrQ.size(), nIn * nOut);
        for (int k = 0; k < wAddrQ.size() && k < nIn * nOut; k++)
            checkOutput($sformatf("%s_waddr%0d", name, k), wAddrQ[k], k);
        for (int k = 0; k < xAddrQ.size() && k < nIn * nOut && nIn > 0; k++)
            checkOutput($sformatf("%s_xaddr%0d", name, k), xAddrQ[k], k % nIn);
    endtask

    function automatic int firstY(input int idx);
        if (idx < yDataQ.size()) return int'(yDataQ[idx]);
        return -1;
    endfunction

    initial begin
        int doneCyc;
        int nIn;
        int nOut;
        int pulses;
        bit seenWr;
        int cyc;

        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        n_in     = '0;
        n_out    = '0;
        repeat (3) @(negedge ap_clk);
        checkOutput("rst_ap_idle", ap_idle, 1);
        checkOutput("rst_ap_done", ap_done, 0);
        checkOutput("rst_ap_ready", ap_ready, 0);
        checkOutput("rst_x_ce0", x_ce0, 0);
        checkOutput("rst_w_ce0", w_ce0, 0);
        checkOutput("rst_y_ce0", y_ce0, 0);
        checkOutput("rst_y_we0", y_we0, 0);
        checkOutput("rst_y_d0", y_d0, 0);
        checkOutput("rst_x_addr", x_address0, 0);
        checkOutput("rst_w_addr", w_address0, 0);
        checkOutput("rst_y_addr", y_address0, 0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        $display("[TB] directed dot products");
        fillRandom();
        xMem[0] = 11'd1; xMem[1] = 11'd2; xMem[2] = 11'd3;
        wMem[0] = 6'd4;  wMem[1] = 6'd5;  wMem[2] = 6'd6;
        applyStimulus(3, 1, 1'b0, doneCyc);
        verifyRun("tp1", 3, 1, doneCyc);
        checkOutput("tp1_y_const", firstY(0), 32);
        checkOutput("tp1_done_const", doneCyc, 7);

        xMem[0] = 11'd10; xMem[1] = 11'd20;
        wMem[0] = 6'd1; wMem[1] = 6'd2; wMem[2] = 6'd3; wMem[3] = 6'd4;
        applyStimulus(2, 2, 1'b0, doneCyc);
        verifyRun("tp2", 2, 2, doneCyc);
        checkOutput("tp2_y0_const", firstY(0), 50);
        checkOutput("tp2_y1_const", firstY(1), 110);

        for (int i = 0; i < 4; i++) begin
            xMem[i] = 11'd2047;
            wMem[i] = 6'd63;
        end
        applyStimulus(4, 1, 1'b0, doneCyc);
        verifyRun("tp3", 4, 1, doneCyc);
`ifdef FC_MAC_CTRL_SAT_EN
        checkOutput("tp3_y_const", firstY(0), 65535);
`else
        checkOutput("tp3_y_const", firstY(0), 57092);
`endif

        $display("[TB] empty neurons and empty layer");
        applyStimulus(0, 3, 1'b0, doneCyc);
        verifyRun("nin0", 0, 3, doneCyc);
        applyStimulus(0, 0, 1'b0, doneCyc);
        verifyRun("nout0", 0, 0, doneCyc);

        $display("[TB] randomized runs");
        for (int r = 0; r < 8; r++) begin
            nIn  = $urandom_range(1, 12);
            nOut = $urandom_range(1, 5);
            fillRandom();
            applyStimulus(nIn, nOut, 1'b0, doneCyc);
            verifyRun($sformatf("rnd%0d", r), nIn, nOut, doneCyc);
        end

        $display("[TB] size limits");
        fillRandom();
        applyStimulus(256, 2, 1'b0, doneCyc);
        verifyRun("max_nin", 256, 2, doneCyc);
        applyStimulus(1, 64, 1'b0, doneCyc);
        verifyRun("max_nout", 1, 64, doneCyc);
        applyStimulus(0, 64, 1'b0, doneCyc);
        verifyRun("nin0_max_nout", 0, 64, doneCyc);
        applyStimulus(256, 64, 1'b0, doneCyc);
        verifyRun("max_both", 256, 64, doneCyc);

        $display("[TB] reset during neuron 1");
        fillRandom();
        @(negedge ap_clk);
        n_in     = 9'd5;
        n_out    = 7'd4;
        ap_start = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_start = 1'b0;
        cyc    = 1;
        seenWr = 1'b0;
        while (!seenWr && cyc < 100) begin
            if (y_we0) seenWr = 1'b1;
            @(negedge ap_clk);
            cyc++;
        end
        @(negedge ap_clk);
        checkOutput("midrun_in_run", x_ce0, 1);
        ap_rst_n = 1'b0;
        #2;
        checkOutput("midrun_rst_idle", ap_idle, 1);
        checkOutput("midrun_rst_x_ce0", x_ce0, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge ap_clk);
            if (y_we0 || y_ce0 || x_ce0 || w_ce0 || ap_done) pulses++;
        end
        checkOutput("postrst_pulses", pulses, 0);
        checkOutput("postrst_idle", ap_idle, 1);
        applyStimulus(5, 4, 1'b0, doneCyc);
        verifyRun("restart", 5, 4, doneCyc);

        $display("[TB] start held through back-to-back runs");
        fillRandom();
        applyStimulus(3, 2, 1'b1, doneCyc);
        verifyRun("held_a", 3, 2, doneCyc);
        applyStimulus(3, 2, 1'b1, doneCyc);
        verifyRun("held_b", 3, 2, doneCyc);
        ap_start = 1'b0;
        repeat (3) @(negedge ap_clk);
        checkOutput("held_end_idle", ap_idle, 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
